// File: rtl/aemb_pkg.sv
// Shared opcode constants and injected instruction words for the aeMB fetch/decode path.
// is_dly_branch flags the branch forms whose following slot must not be displaced.
package aemb_pkg;

  localparam logic [5:0]  OPC_IMM  = 6'o54;
  localparam logic [5:0]  OPC_BRU  = 6'o46;
  localparam logic [5:0]  OPC_BCC  = 6'o47;
  localparam logic [5:0]  OPC_RTD  = 6'o55;

  localparam logic [31:0] NOP_WORD = 32'h8000_0000;
  localparam logic [31:0] INT_WORD = 32'hB9DC_0010;

  // Bit 3 of the opcode selects register/immediate form; mask it so both forms match.
  // BRU carries its delay bit in rA[4], BCC in rD[4]; RTD always has a delay slot.
  function automatic logic is_dly_branch(input logic [31:0] w);
    logic [5:0] opc_m;
    opc_m = w[31:26] & 6'b110111;
    return ((opc_m == OPC_BRU) && w[20]) ||
           ((opc_m == OPC_BCC) && w[25]) ||
           (w[31:26] == OPC_RTD);
  endfunction

endpackage

// File: rtl/aemb_ibuf_hold.sv
// One-entry skid buffer: parks an instruction acknowledged while the pipeline is stalled.
// The strobe is withheld while the entry is occupied so no second word can arrive.
module aemb_ibuf_hold (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ena_i,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        stb_o,
  output logic        vld_o,
  output logic [31:0] dat_o
);

  logic        run_q;
  logic        vld_q;
  logic [31:0] dat_q;

  assign stb_o = run_q & ~vld_q;
  assign vld_o = vld_q;
  assign dat_o = dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (ena_i) begin
        vld_q <= 1'b0;
      end else if (ack_i && stb_o) begin
        vld_q <= 1'b1;
        dat_q <= dat_i;
      end
    end
  end

endmodule

// File: rtl/aemb_ibuf.sv
// Instruction buffer and decode register: IMM-prefix extension, branch squash and
// interrupt injection, one gena cycle from acknowledge to decoded fields.
module aemb_ibuf
  import aemb_pkg::*;
(
  input  logic        gclk,
  input  logic        grst,
  input  logic        gena,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  input  logic        rBRA,
  input  logic        rDLY,
  input  logic        rMSR_IE,
  input  logic        sys_int_i,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [10:0] rALT,
  output logic [15:0] rIMM,
  output logic [31:0] rSIMM,
  output logic        rINT,
  output logic        fSTALL
);

  logic        hold_vld;
  logic [31:0] hold_dat;
  logic [31:0] src_word;
  logic [31:0] dec_d, dec_q;
  logic [31:0] simm_d, simm_q;
  logic [15:0] immhi_d, immhi_q;
  logic        int_d, int_q;
  logic        imm_d, imm_q;
  logic        sync_q, intreq_q;
  logic        fskip, inject;

  aemb_ibuf_hold u_hold (
    .clk_i  (gclk),
    .rst_ni (grst),
    .ena_i  (gena),
    .ack_i  (iwb_ack_i),
    .dat_i  (iwb_dat_i),
    .stb_o  (iwb_stb_o),
    .vld_o  (hold_vld),
    .dat_o  (hold_dat)
  );

  assign fSTALL = iwb_stb_o & ~iwb_ack_i & ~hold_vld;

  always_comb begin
    src_word = hold_vld ? hold_dat : iwb_dat_i;
    fskip    = rBRA & ~rDLY;
    // Never split an IMM pair or displace a delay slot; the displaced word is dropped
    // and refetched by the consumer through the linked PC.
    inject   = intreq_q & rMSR_IE & ~rBRA & ~imm_q & ~is_dly_branch(dec_q);

    dec_d    = dec_q;
    int_d    = int_q;
    imm_d    = imm_q;
    immhi_d  = immhi_q;
    simm_d   = simm_q;

    if (gena) begin
      if (fskip) begin
        dec_d = NOP_WORD;
        int_d = 1'b0;
      end else if (inject) begin
        dec_d = INT_WORD;
        int_d = 1'b1;
      end else begin
        dec_d = src_word;
        int_d = 1'b0;
      end
      simm_d = imm_q ? {immhi_q, dec_d[15:0]} : {{16{dec_d[15]}}, dec_d[15:0]};
      imm_d  = (dec_d[31:26] == OPC_IMM);
      if (imm_d) immhi_d = dec_d[15:0];
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      dec_q    <= NOP_WORD;
      simm_q   <= '0;
      immhi_q  <= '0;
      int_q    <= 1'b0;
      imm_q    <= 1'b0;
      sync_q   <= 1'b0;
      intreq_q <= 1'b0;
    end else begin
      dec_q    <= dec_d;
      simm_q   <= simm_d;
      immhi_q  <= immhi_d;
      int_q    <= int_d;
      imm_q    <= imm_d;
      sync_q   <= sys_int_i;
      intreq_q <= sync_q;
    end
  end

  assign rOPC  = dec_q[31:26];
  assign rRD   = dec_q[25:21];
  assign rRA   = dec_q[20:16];
  assign rRB   = dec_q[15:11];
  assign rALT  = dec_q[10:0];
  assign rIMM  = dec_q[15:0];
  assign rSIMM = simm_q;
  assign rINT  = int_q;

endmodule
